banco_registradores: RTL and testbench
======================================

BANCO_REGISTRADORES -- requirements
Module: banco_registradores

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each register and of all data ports.
REQ-002 Parameter ADDR_WIDTH, default 5: width of register addresses; register count is 2**ADDR_WIDTH (32).
REQ-003 The design SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Clock  input  1  sole clock; all writes occur on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high; clears the register array.
REQ-006 regWrite  input  1  write enable, sampled at the rising edge of Clock.
REQ-007 regLeitura1  input  ADDR_WIDTH  read address, port 1.
REQ-008 regLeitura2  input  ADDR_WIDTH  read address, port 2.
REQ-009 regEscrita  input  ADDR_WIDTH  write address.
REQ-010 DadosEscrita  input  DATA_WIDTH  write data.
REQ-011 DadosLeitura1  output  DATA_WIDTH  read data, port 1.
REQ-012 DadosLeitura2  output  DATA_WIDTH  read data, port 2.

Function
REQ-013 Storage SHALL be 2**ADDR_WIDTH registers of DATA_WIDTH bits, indexed 0..31.
REQ-014 Register 0 SHALL read as all-zero at all times.
REQ-015 Writes to register 0 SHALL be discarded, whatever the value of regWrite.
REQ-016 On a rising edge of Clock with regWrite=1, Reset=0 and regEscrita!=0, register[regEscrita] SHALL take the value of DadosEscrita.
REQ-017 With regWrite=0, no register SHALL change.
REQ-018 Only the addressed register SHALL change; all others SHALL hold their value.
REQ-019 Reads SHALL be combinational with zero latency: DadosLeitura1=register[regLeitura1] and DadosLeitura2=register[regLeitura2], updating within the same cycle on any change of address or stored content.
REQ-020 The two read ports SHALL be independent.
REQ-021 Both read ports addressing the same register SHALL return identical data.
REQ-022 Read-during-write to the same address SHALL return the old value until the rising edge, and the new value immediately after it.
REQ-023 There SHALL be no write-to-read forwarding.
REQ-024 Address range SHALL be exactly the full ADDR_WIDTH space; there is no out-of-range case.
REQ-025 Read outputs SHALL never be X/Z after reset has been applied.

Reset
REQ-026 Assertion of Reset SHALL immediately clear all registers to 0, without waiting for a clock edge.
REQ-027 While Reset is high, both read outputs SHALL be 0 for every address.
REQ-028 While Reset is high, writes SHALL be ignored.
REQ-029 A write coinciding with a Reset assertion SHALL be lost; Reset has priority.
REQ-030 After Reset deasserts, the first rising edge with regWrite=1 SHALL perform a normal write.

Verification
REQ-031 Write value: after Reset, regWrite=1, regEscrita=5, DadosEscrita=192, one rising edge, then regWrite=0; set regLeitura1=5, regLeitura2=0 -> DadosLeitura1=192, DadosLeitura2=0.
REQ-032 Register 0 protection: regWrite=1, regEscrita=0, DadosEscrita=999, one rising edge -> reading address 0 on either port gives 0, and R5 still reads 192.
REQ-033 Write disable: regWrite=0, regEscrita=7, DadosEscrita=0xDEADBEEF, several edges -> R7 reads 0.
REQ-034 Dual read and boundary: write R31=0xFFFFFFFF and R1=0x00000001; set regLeitura1=31, regLeitura2=1 -> outputs 0xFFFFFFFF and 0x00000001; swap addresses -> outputs swap in the same cycle.
REQ-035 Read-during-write: R3=10; read port 1 on 3 while writing 20 to R3 -> 10 before the edge, 20 after it.
REQ-036 Asynchronous reset: with R5=192 loaded, pulse Reset between clock edges -> DadosLeitura1 for address 5 drops to 0 before the next edge; a subsequent write of 7 to R5 reads back 7.

Source files
------------

// File: rtl/banco_registradores.sv
// Register file with two combinational read ports, one synchronous write port and
// an asynchronous clear. Register 0 is hardwired to zero.
module banco_registradores #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  regWrite,
    input  logic [ADDR_WIDTH-1:0] regLeitura1,
    input  logic [ADDR_WIDTH-1:0] regLeitura2,
    input  logic [ADDR_WIDTH-1:0] regEscrita,
    input  logic [DATA_WIDTH-1:0] DadosEscrita,
    output logic [DATA_WIDTH-1:0] DadosLeitura1,
    output logic [DATA_WIDTH-1:0] DadosLeitura2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // Read view of every register; entry 0 is a constant and has no storage.
    logic [DATA_WIDTH-1:0] rd_view [NUM_REGS];

    assign rd_view[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : gen_regs
            logic                  wr_en;
            logic [DATA_WIDTH-1:0] reg_q;
            logic [DATA_WIDTH-1:0] reg_d;

            assign wr_en = regWrite && (regEscrita == ADDR_WIDTH'(gi));

            always_comb begin
                reg_d = reg_q;
                if (wr_en) begin
                    reg_d = DadosEscrita;
                end
            end

            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign rd_view[gi] = reg_q;
        end
    endgenerate

    // No forwarding: a write in flight is only visible after the edge.
    assign DadosLeitura1 = rd_view[regLeitura1];
    assign DadosLeitura2 = rd_view[regLeitura2];

endmodule

// File: tb/tb_banco_registradores.sv
// Directed bench for banco_registradores: stimulus pushes expected read data into a
// scoreboard queue and a separate monitor pops and compares against the DUT ports.
module tb_banco_registradores;

    logic        Clock;
    logic        Reset;
    logic        regWrite;
    logic [4:0]  regLeitura1;
    logic [4:0]  regLeitura2;
    logic [4:0]  regEscrita;
    logic [31:0] DadosEscrita;
    logic [31:0] DadosLeitura1;
    logic [31:0] DadosLeitura2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t sb_q[$];
    event sample_ev;

    banco_registradores #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .regWrite     (regWrite),
        .regLeitura1  (regLeitura1),
        .regLeitura2  (regLeitura2),
        .regEscrita   (regEscrita),
        .DadosEscrita (DadosEscrita),
        .DadosLeitura1(DadosLeitura1),
        .DadosLeitura2(DadosLeitura2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Monitor: whenever stimulus presents a read, compare both ports with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                total++;
                if (DadosLeitura1 !== e.e1) begin
                    bad++;
                    $display("FAIL %s port1: got %h expected %h", e.name, DadosLeitura1, e.e1);
                end else begin
                    $display("ok   %s port1 = %h", e.name, DadosLeitura1);
                end
                total++;
                if (DadosLeitura2 !== e.e2) begin
                    bad++;
                    $display("FAIL %s port2: got %h expected %h", e.name, DadosLeitura2, e.e2);
                end else begin
                    $display("ok   %s port2 = %h", e.name, DadosLeitura2);
                end
            end
        end
    end

    task automatic check(input string name, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        regLeitura1 = a1;
        regLeitura2 = a2;
        #1;
        e.name = name;
        e.e1   = e1;
        e.e2   = e2;
        sb_q.push_back(e);
        ->sample_ev;
        #1;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge Clock);
        regWrite     = 1'b1;
        regEscrita   = addr;
        DadosEscrita = data;
        @(negedge Clock);
        regWrite     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset        = 1'b1;
        regWrite     = 1'b0;
        regLeitura1  = '0;
        regLeitura2  = '0;
        regEscrita   = '0;
        DadosEscrita = '0;

        @(negedge Clock);
        check("reset_r0_r5", 5'd0, 5'd5, 32'd0, 32'd0);
        check("reset_r31_r1", 5'd31, 5'd1, 32'd0, 32'd0);
        Reset = 1'b0;

        write_reg(5'd5, 32'd192);
        check("write_r5", 5'd5, 5'd0, 32'd192, 32'd0);

        write_reg(5'd0, 32'd999);
        check("r0_protect", 5'd0, 5'd0, 32'd0, 32'd0);
        check("r5_same_both", 5'd5, 5'd5, 32'd192, 32'd192);

        @(negedge Clock);
        regWrite     = 1'b0;
        regEscrita   = 5'd7;
        DadosEscrita = 32'hDEADBEEF;
        repeat (3) @(negedge Clock);
        check("write_disable_r7", 5'd7, 5'd7, 32'd0, 32'd0);

        write_reg(5'd31, 32'hFFFFFFFF);
        write_reg(5'd1, 32'h00000001);
        check("dual_read", 5'd31, 5'd1, 32'hFFFFFFFF, 32'h00000001);
        check("dual_swap", 5'd1, 5'd31, 32'h00000001, 32'hFFFFFFFF);

        write_reg(5'd3, 32'd10);
        @(negedge Clock);
        regWrite     = 1'b1;
        regEscrita   = 5'd3;
        DadosEscrita = 32'd20;
        check("rdw_before_edge", 5'd3, 5'd5, 32'd10, 32'd192);
        @(posedge Clock);
        check("rdw_after_edge", 5'd3, 5'd5, 32'd20, 32'd192);
        @(negedge Clock);
        regWrite = 1'b0;

        check("others_hold", 5'd5, 5'd31, 32'd192, 32'hFFFFFFFF);
        check("unwritten_zero", 5'd2, 5'd4, 32'd0, 32'd0);

        // Reset pulse between edges, with a write attempted while it is high.
        @(negedge Clock);
        #2;
        Reset        = 1'b1;
        check("async_reset_clear", 5'd5, 5'd31, 32'd0, 32'd0);
        regWrite     = 1'b1;
        regEscrita   = 5'd9;
        DadosEscrita = 32'd55;
        @(posedge Clock);
        check("write_ignored_in_reset", 5'd9, 5'd1, 32'd0, 32'd0);
        @(negedge Clock);
        regWrite = 1'b0;
        Reset    = 1'b0;

        write_reg(5'd5, 32'd7);
        check("write_after_reset", 5'd5, 5'd9, 32'd7, 32'd0);

        // Reset asserted at the same edge as a write: the write is lost.
        @(negedge Clock);
        regWrite     = 1'b1;
        regEscrita   = 5'd12;
        DadosEscrita = 32'd77;
        @(posedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        regWrite = 1'b0;
        check("reset_wins_over_write", 5'd12, 5'd5, 32'd0, 32'd0);
        Reset = 1'b0;

        write_reg(5'd12, 32'h0000ABCD);
        check("normal_write_after", 5'd12, 5'd0, 32'h0000ABCD, 32'd0);

        #2;
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
